// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the round-robin RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  // gnt_id must stay at least one bit wide even for degenerate requester counts.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: requests in, ack/read data/status out.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]       rdata;
  logic [ID_W-1:0]             gnt_id;
  logic                        busy;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  ack, rdata, gnt_id, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output ack, rdata, gnt_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', cyclically.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  last,
  output logic             any_elig,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W-1:0] idx;
  logic            found;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    any_elig = |eligible;
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    // k runs 1..N_REQ so 'last' itself is considered only after everyone else.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between N_REQ requesters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  localparam int ID_W = id_width(N_REQ);

  arb_state_e            state;
  logic [ID_W-1:0]       last_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [N_REQ-1:0]      eligible;
  logic                  any_elig;
  logic [ID_W-1:0]       winner;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  we_sel;

  // A requester whose ack is high this cycle is masked so a held req is not granted twice.
  assign eligible = bus.req & ~bus.ack;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .any_elig (any_elig),
    .winner   (winner)
  );

  assign addr_sel  = bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_sel = bus.req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign we_sel    = bus.req_we[winner];

  assign bus.busy  = (state == ACCESS);

  // Driver enable comes straight from registered strobes, so it drops with the async reset.
  assign mem_data  = (mem_cs && mem_we) ? wdata_q : 'z;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      mem_addr   <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
      wdata_q    <= '0;
      bus.ack    <= '0;
      bus.rdata  <= '0;
      bus.gnt_id <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            mem_addr   <= addr_sel;
            mem_cs     <= 1'b1;
            mem_we     <= we_sel;
            mem_oe     <= ~we_sel;
            wdata_q    <= wdata_sel;
            bus.gnt_id <= winner;
            last_q     <= winner;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          bus.ack[bus.gnt_id] <= 1'b1;
          if (!mem_we) begin
            bus.rdata <= mem_data;
          end
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          mem_oe <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM and an ack scoreboard.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int n_access = 0;

  typedef struct {
    int           id;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rd_model;

  ram_arbiter_if #(.N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe)
  );

  always #5 clk = ~clk;

  // Weak pull makes an undriven bus read as all ones.
  for (genvar b = 0; b < DW; b++) begin : g_pull
    pullup (mem_data[b]);
  end

  // Behavioural RAM: read latched on the falling edge, write committed on the rising edge.
  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] ram_q;

  always @(negedge clk) if (mem_cs && mem_oe && !mem_we) ram_q <= ram_mem[mem_addr];
  always @(posedge clk) if (mem_cs && mem_we) ram_mem[mem_addr] <= mem_data;
  always @(posedge clk) if (mem_cs) n_access <= n_access + 1;
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 'z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && bus.ack != '0) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_id", 32'(bus.ack), 32'(1 << e.id));
        check("ack_rdata", 32'(bus.rdata), 32'(e.rdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input bit we, input logic [DW-1:0] exp_rd);
    exp_t e;
    if (!we) rd_model = exp_rd;
    e.id    = id;
    e.rdata = rd_model;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int id, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    bus.req_addr[id*AW +: AW]  = addr;
    bus.req_wdata[id*DW +: DW] = wdata;
    bus.req_we[id]             = we;
    bus.req[id]                = 1'b1;
  endtask

  task automatic wait_ack(input int id, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      cycles++;
      if (bus.ack[id]) seen = 1'b1;
    end
    check($sformatf("ack%0d_seen", id), 32'(seen), 32'd1);
  endtask

  task automatic do_access(input int id, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    int cyc;
    drive_req(id, we, addr, wdata);
    push(id, we, exp_rd);
    wait_ack(id, cyc);
    check($sformatf("latency%0d", id), 32'(cyc), 32'd2);
    bus.req[id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acks, t_prev, t_first, acc0;
    logic [DW-1:0] mem0;

    for (int a = 0; a < 65536; a++) ram_mem[a] = '0;
    ram_q         = '0;
    rd_model      = '0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #22 rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_gnt",    32'(bus.gnt_id), 32'd0);
    check("rst_ack",    32'(bus.ack),    32'd0);
    check("rst_rdata",  32'(bus.rdata),  32'd0);
    check("rst_cs",     32'(mem_cs),     32'd0);
    check("rst_we_oe",  32'({mem_we, mem_oe}), 32'd0);
    check("rst_addr",   32'(mem_addr),   32'd0);
    check("rst_bus_z",  32'(mem_data),   32'hFF);

    // 1: write then read back through the other requester
    tick();
    drive_req(0, 1'b1, 16'h0010, 8'hA5);
    push(0, 1'b1, 8'h00);
    tick();
    check("w_busy",  32'(bus.busy), 32'd1);
    check("w_gnt",   32'(bus.gnt_id), 32'd0);
    check("w_strb",  32'({mem_cs, mem_we, mem_oe}), 32'b110);
    check("w_addr",  32'(mem_addr), 32'h0010);
    check("w_drive", 32'(mem_data), 32'hA5);
    tick();
    check("w_ack",   32'(bus.ack), 32'b01);
    check("w_oe",    32'(mem_oe), 32'd0);
    check("w_cs_off", 32'(mem_cs), 32'd0);
    bus.req[0] = 1'b0;
    tick();
    check("w_mem",   32'(ram_mem[16'h0010]), 32'hA5);
    check("idle_bus_z", 32'(mem_data), 32'hFF);

    drive_req(1, 1'b0, 16'h0010, 8'h00);
    push(1, 1'b0, 8'hA5);
    tick();
    check("r_gnt",   32'(bus.gnt_id), 32'd1);
    check("r_strb",  32'({mem_cs, mem_we, mem_oe}), 32'b101);
    @(negedge clk);
    #1;
    check("r_bus",   32'(mem_data), 32'hA5);
    tick();
    check("r_ack",   32'(bus.ack), 32'b10);
    check("r_rdata", 32'(bus.rdata), 32'hA5);
    bus.req[1] = 1'b0;
    tick();

    // 2: contention, both held and re-requesting; grants must alternate
    do_access(0, 1'b1, 16'h0001, 8'h11, 8'h00);
    do_access(1, 1'b1, 16'h0002, 8'h22, 8'h00);
    drive_req(0, 1'b0, 16'h0001, 8'h00);
    drive_req(1, 1'b0, 16'h0002, 8'h00);
    push(0, 1'b0, 8'h11);
    push(1, 1'b0, 8'h22);
    push(0, 1'b0, 8'h11);
    push(1, 1'b0, 8'h22);
    acks = 0; t_prev = 0; t_first = 0;
    for (int c = 1; c <= 24 && acks < 4; c++) begin
      tick();
      if (bus.ack != '0) begin
        if (acks == 0) t_first = c;
        else check("cont_spacing", 32'(c - t_prev), 32'd2);
        t_prev = c;
        acks++;
      end
    end
    bus.req = '0;
    check("cont_acks", 32'(acks), 32'd4);
    check("cont_span", 32'(t_prev - t_first), 32'd6);
    tick();

    // 3: req0 held across its ack; req1 pending gets the ack0 cycle
    acc0 = n_access;
    drive_req(0, 1'b0, 16'h0001, 8'h00);
    drive_req(1, 1'b0, 16'h0002, 8'h00);
    push(0, 1'b0, 8'h11);
    push(1, 1'b0, 8'h22);
    wait_ack(0, cyc);
    tick();
    check("hold_gnt",  32'(bus.gnt_id), 32'd1);
    check("hold_busy", 32'(bus.busy), 32'd1);
    check("hold_ack",  32'(bus.ack), 32'd0);
    bus.req[0] = 1'b0;
    wait_ack(1, cyc);
    bus.req[1] = 1'b0;
    repeat (3) tick();
    check("hold_idle",   32'(bus.busy), 32'd1 - 32'd1);
    check("hold_access", 32'(n_access - acc0), 32'd2);

    // 4: reset during a write access
    check("rw_pre", 32'(ram_mem[16'h0020]), 32'h00);
    drive_req(0, 1'b1, 16'h0020, 8'h3C);
    tick();
    check("rw_cs_on", 32'(mem_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_cs_off", 32'(mem_cs), 32'd0);
    check("rw_busy",   32'(bus.busy), 32'd0);
    check("rw_bus_z",  32'(mem_data), 32'hFF);
    bus.req = '0;
    rd_model = '0;
    #10 rst_n = 1'b1;
    tick();
    check("rw_mem", 32'(ram_mem[16'h0020]), 32'h00);
    do_access(0, 1'b0, 16'h0020, 8'h00, 8'h00);
    tick();

    // 6: top-of-range address, no wrap into address 0
    mem0 = 8'h00;
    do_access(1, 1'b1, 16'hFFFF, 8'h5A, 8'h00);
    tick();
    do_access(0, 1'b0, 16'hFFFF, 8'h00, 8'h5A);
    tick();
    check("bnd_rdata", 32'(bus.rdata), 32'h5A);
    check("bnd_mem0",  32'(ram_mem[16'h0000]), 32'(mem0));
    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
